// File: rtl/bcd_scan_driver.sv
// Time-multiplexed BCD seven-segment driver with frame-synchronous digit snapshot,
// leading-zero blanking and a per-slot ghost-suppression blank interval.
module bcd_scan_driver #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter int unsigned ACTIVE_LOW   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [4*NUM_DIGITS-1:0]       digits_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          en,
   input  logic                          lz_blank,
   output logic [NUM_DIGITS-1:0]         anode,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [$clog2(NUM_DIGITS)-1:0] cur_dig,
   output logic                          frame_done
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

   localparam logic                  OFF       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [6:0]            SEG_OFF   = {7{OFF}};
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{OFF}};

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Scan state
   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Frame-synchronous snapshot of the inputs
   logic [NUM_DIGITS-1:0][3:0] shadow_dig_q;
   logic [NUM_DIGITS-1:0]      shadow_dp_q;

   // Registered outputs
   logic [NUM_DIGITS-1:0] anode_q;
   logic [6:0]            seg_q;
   logic                  dp_q;
   logic [IDX_W-1:0]      cur_dig_q;
   logic                  frame_done_q;

   logic                  slot_last;
   logic                  frame_evt;
   logic                  slot_open;
   logic                  drive_on;
   logic [NUM_DIGITS-1:0] blank_mask;
   logic [NUM_DIGITS-1:0] anode_onehot;
   logic [3:0]            cur_code;
   logic [6:0]            seg_code;

   function automatic logic [6:0] bcd_decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Prescaler and digit index
   always_comb begin
      slot_last = (div_q == DIV_LAST);
      frame_evt = slot_last && (idx_q == IDX_LAST);
      div_d     = slot_last ? '0 : div_q + DIV_W'(1);
      idx_d     = idx_q;
      if (slot_last) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // The first BLANK_CYCLES of every slot keep all anodes dark to hide ghosting.
   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign slot_open = 1'b1;
   end else begin : g_blank
      assign slot_open = (div_q >= DIV_W'(BLANK_CYCLES));
   end

   // A digit above position 0 is blanked when it and every higher digit are zero.
   always_comb begin
      logic zero_run;
      blank_mask = '0;
      zero_run   = lz_blank;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (shadow_dig_q[i] == 4'd0);
         blank_mask[i] = zero_run;
      end
   end

   always_comb begin
      anode_onehot        = '0;
      anode_onehot[idx_q] = 1'b1;
      cur_code            = shadow_dig_q[idx_q];
      seg_code            = bcd_decode(cur_code);
      drive_on            = en && slot_open && !blank_mask[idx_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q        <= '0;
         idx_q        <= '0;
         shadow_dig_q <= '0;
         shadow_dp_q  <= '0;
         anode_q      <= ANODE_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= OFF;
         cur_dig_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_evt;
         cur_dig_q    <= idx_q;
         if (frame_evt) begin
            shadow_dig_q <= digits_in;
            shadow_dp_q  <= dp_in;
         end
         if (drive_on) begin
            anode_q <= anode_onehot ^ ANODE_OFF;
            seg_q   <= seg_code ^ SEG_OFF;
            dp_q    <= shadow_dp_q[idx_q] ^ OFF;
         end else begin
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= OFF;
         end
      end
   end

   assign anode      = anode_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign cur_dig    = cur_dig_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Randomised bench for bcd_scan_driver against a cycle-count based reference model.
module tb_bcd_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BC = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   digits_in;
   logic [3:0]    dp_in;
   logic          en;
   logic          lz_blank;
   logic [3:0]    anode;
   logic [6:0]    seg;
   logic          dp;
   logic [1:0]    cur_dig;
   logic          frame_done;

   bcd_scan_driver #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .en        (en),
      .lz_blank  (lz_blank),
      .anode     (anode),
      .seg       (seg),
      .dp        (dp),
      .cur_dig   (cur_dig),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   // Reference model: time since reset plus the snapshot taken at each frame end
   int         t;
   int         sh_dig [ND];
   logic [3:0] sh_dp;
   bit         have_exp = 0;
   logic [3:0] exp_anode;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic [1:0] exp_cur;
   logic       exp_fd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] d;
      int nz;
      d  = '0;
      nz = $urandom_range(0, ND);
      for (int i = 0; i < nz; i++) begin
         if ($urandom_range(0, 5) == 0) d[4*i +: 4] = 4'($urandom_range(10, 15));
         else d[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return d;
   endfunction

   task automatic cycle(input logic r, input logic [15:0] d, input logic [3:0] p,
                        input logic e, input logic l);
      int  div, idx, msd;
      bit  on;
      @(negedge clk);
      if (have_exp) begin
         check_val("anode", 32'(anode), 32'(exp_anode));
         check_val("seg", 32'(seg), 32'(exp_seg));
         check_val("dp", 32'(dp), 32'(exp_dp));
         check_val("cur_dig", 32'(cur_dig), 32'(exp_cur));
         check_val("frame_done", 32'(frame_done), 32'(exp_fd));
      end
      rst       = r;
      digits_in = d;
      dp_in     = p;
      en        = e;
      lz_blank  = l;
      if (r) begin
         exp_anode = 4'hF;
         exp_seg   = 7'h7F;
         exp_dp    = 1'b1;
         exp_cur   = 2'd0;
         exp_fd    = 1'b0;
         t         = 0;
         for (int i = 0; i < ND; i++) sh_dig[i] = 0;
         sh_dp = '0;
      end else begin
         div = t % RD;
         idx = (t / RD) % ND;
         msd = 0;
         for (int i = 0; i < ND; i++) if (sh_dig[i] != 0) msd = i;
         on = e && (div >= BC) && !(l && idx > msd);
         exp_anode = on ? ~(4'b0001 << idx) : 4'hF;
         exp_seg   = on ? ~dec_tab[sh_dig[idx]] : 7'h7F;
         exp_dp    = on ? ~sh_dp[idx] : 1'b1;
         exp_cur   = 2'(idx);
         exp_fd    = ((t % (RD * ND)) == RD * ND - 1);
         if (exp_fd) begin
            for (int i = 0; i < ND; i++) sh_dig[i] = int'(d[4*i +: 4]);
            sh_dp = p;
         end
         t++;
      end
      have_exp = 1;
      cyc++;
   endtask

   initial begin
      logic [15:0] d;
      logic [3:0]  p;
      logic        e, l, r;

      rst = 1'b1; digits_in = '0; dp_in = '0; en = 1'b0; lz_blank = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0, 4'h0, 1'b0, 1'b0);

      for (int i = 0; i < 50; i++) cycle(1'b0, 16'h4321, 4'h0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0050, 4'h0, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0000, 4'hF, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 16'h1111, 4'h0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b0, 16'h222C, 4'h1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)  cycle(1'b0, 16'h222C, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) cycle(1'b0, 16'h222C, 4'h1, 1'b1, 1'b0);
      cycle(1'b1, 16'h222C, 4'h1, 1'b1, 1'b0);

      d = 16'h9876; p = 4'h5; l = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) d = rand_digits();
         if ($urandom_range(0, 15) == 0) p = 4'($urandom);
         if ($urandom_range(0, 40) == 0) l = ~l;
         e = ($urandom_range(0, 9) != 0);
         r = ($urandom_range(0, 299) == 0);
         cycle(r, d, p, e, l);
      end
      cycle(1'b0, d, p, 1'b1, l);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
